lnx_norm: RTL and testbench

LNX_NORM -- requirements
Module: lnx_norm

---
 rtl/lnx_norm_if.sv | 14 +
 rtl/lnx_norm.sv | 130 +++++++++++++
 tb/tb_lnx_norm.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/lnx_norm_if.sv
// Handshake and data bundle between the normalizer and its requester.
// The master drives START/IN; the slave (lnx_norm) returns OUT/K/READY/VALID/FLAG.
interface lnx_norm_if;
  logic              START;
  logic [15:0]       IN;
  logic [15:0]       OUT;
  logic signed [4:0] K;
  logic              READY;
  logic              VALID;
  logic              FLAG;

  modport master (output START, IN, input OUT, K, READY, VALID, FLAG);
  modport slave  (input START, IN, output OUT, K, READY, VALID, FLAG);
endinterface

// File: rtl/lnx_norm.sv
// Normalizes unsigned Q8.8 x into m in [1,2) and exponent K with x = m * 2^K, one shift per cycle.
// Define LNX_NORM_ROUND_EN to round the mantissa half-up using the last bit shifted out.
module lnx_norm (
  input  logic       CLK,
  input  logic       RESETn,
  lnx_norm_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [15:0]       work_q, work_d;
  logic signed [4:0] exp_q, exp_d;
  logic [15:0]       out_q, out_d;
  logic signed [4:0] k_q, k_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              flag_q, flag_d;
`ifdef LNX_NORM_ROUND_EN
  logic              guard_q, guard_d;
  logic [9:0]        round_sum;

  // Only bits [8:0] can be nonzero once normalized, so a carry into bit 9 means 2.0.
  assign round_sum = {1'b0, work_q[8:0]} + {9'd0, guard_q};
`endif

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    exp_d   = exp_q;
    out_d   = out_q;
    k_d     = k_q;
    ready_d = ready_q;
    valid_d = 1'b0;
    flag_d  = flag_q;
`ifdef LNX_NORM_ROUND_EN
    guard_d = guard_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.START && ready_q) begin
          state_d = S_SHIFT;
          work_d  = bus.IN;
          exp_d   = '0;
          ready_d = 1'b0;
`ifdef LNX_NORM_ROUND_EN
          guard_d = 1'b0;
`endif
        end
      end
      S_SHIFT: begin
        // Zero must be caught first, otherwise it would left-shift forever.
        if (work_q == 16'd0) begin
          state_d = S_DONE;
          valid_d = 1'b1;
          out_d   = '0;
          k_d     = '0;
          flag_d  = 1'b1;
        end else if (|work_q[15:9]) begin
          work_d  = {1'b0, work_q[15:1]};
          exp_d   = exp_q + 5'sd1;
`ifdef LNX_NORM_ROUND_EN
          guard_d = work_q[0];
`endif
        end else if (!work_q[8]) begin
          work_d  = {work_q[14:0], 1'b0};
          exp_d   = exp_q - 5'sd1;
        end else begin
          state_d = S_DONE;
          valid_d = 1'b1;
          flag_d  = 1'b0;
`ifdef LNX_NORM_ROUND_EN
          if (round_sum[9]) begin
            out_d = 16'h0100;
            k_d   = exp_q + 5'sd1;
          end else begin
            out_d = {7'd0, round_sum[8:0]};
            k_d   = exp_q;
          end
`else
          out_d = work_q;
          k_d   = exp_q;
`endif
        end
      end
      S_DONE: begin
        // VALID is high for this whole state; READY comes back on the way out.
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      exp_q   <= '0;
      out_q   <= '0;
      k_q     <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      flag_q  <= 1'b0;
`ifdef LNX_NORM_ROUND_EN
      guard_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      exp_q   <= exp_d;
      out_q   <= out_d;
      k_q     <= k_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      flag_q  <= flag_d;
`ifdef LNX_NORM_ROUND_EN
      guard_q <= guard_d;
`endif
    end
  end

  assign bus.OUT   = out_q;
  assign bus.K     = k_q;
  assign bus.READY = ready_q;
  assign bus.VALID = valid_q;
  assign bus.FLAG  = flag_q;
endmodule

// File: tb/tb_lnx_norm.sv
// Scoreboard bench for lnx_norm: a driver pushes model results, a negedge monitor pops and compares.
// Latency is the number of rising edges from the accepting edge to the edge that samples VALID high.
module tb_lnx_norm;
  logic clk = 1'b0;
  logic RESETn;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic [15:0]       out;
    logic signed [4:0] k;
    logic              flag;
    int                lat;
    int                accept_edge;
  } exp_t;

  exp_t sb[$];

  lnx_norm_if bus_if ();

  lnx_norm dut (
    .CLK    (clk),
    .RESETn (RESETn),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // x = m * 2^K with m in [1,2): K follows directly from the position of the leading one.
  function automatic exp_t model(input logic [15:0] x);
    exp_t e;
    int p, k, m, g;
    e.accept_edge = 0;
    if (x == 16'd0) begin
      e.out = 16'd0; e.k = 5'sd0; e.flag = 1'b1; e.lat = 2;
      return e;
    end
    p = 15;
    while (x[p] == 1'b0) p--;
    k = p - 8;
    if (k >= 0) begin
      m = int'(x) >> k;
      g = (k > 0) ? int'(x[k-1]) : 0;
    end else begin
      m = int'(x) << (-k);
      g = 0;
    end
    e.lat = ((k < 0) ? -k : k) + 2;
`ifdef LNX_NORM_ROUND_EN
    m = m + g;
    if (m == 512) begin
      m = 256;
      k = k + 1;
    end
`else
    if (g > 1) m = 0;
`endif
    e.out  = 16'(m);
    e.k    = 5'(k);
    e.flag = 1'b0;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every VALID must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (RESETn && bus_if.VALID) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual=1 required=0 at edge %0d", cyc + 1);
        end else begin
          e = sb.pop_front();
          check("out", int'(bus_if.OUT), int'(e.out));
          check("k", int'($signed(bus_if.K)), int'(e.k));
          check("flag", int'(bus_if.FLAG), int'(e.flag));
          check("latency", cyc + 1 - e.accept_edge, e.lat);
          $display("txn out=%04h k=%0d flag=%0b lat=%0d", bus_if.OUT, $signed(bus_if.K),
                   bus_if.FLAG, cyc + 1 - e.accept_edge);
        end
      end
    end
  end

  // Issue one request at a negedge; optionally keep START toggling while busy to prove it is ignored.
  task automatic issue(input logic [15:0] x, input int junk);
    exp_t e;
    int waited = 0;
    while (!bus_if.READY && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_start", int'(bus_if.READY), 1);
    if (!bus_if.READY) return;
    bus_if.START = 1'b1;
    bus_if.IN    = x;
    e = model(x);
    e.accept_edge = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    for (int j = 0; j < junk; j++) begin
      if (bus_if.READY) break;
      bus_if.START = 1'b1;
      bus_if.IN    = 16'($urandom);
      @(negedge clk);
    end
    bus_if.START = 1'b0;
    bus_if.IN    = 16'($urandom);
  endtask

  task automatic drain();
    int waited = 0;
    while (sb.size() != 0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    logic [15:0] directed [8];
    directed = '{16'h0E80, 16'h0001, 16'h0100, 16'h0000, 16'hFFFF, 16'h0200, 16'h01FF, 16'h00FF};
    RESETn       = 1'b0;
    bus_if.START = 1'b0;
    bus_if.IN    = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_ready", int'(bus_if.READY), 1);
    check("rst_valid", int'(bus_if.VALID), 0);
    check("rst_flag", int'(bus_if.FLAG), 0);
    check("rst_out", int'(bus_if.OUT), 0);
    check("rst_k", int'($signed(bus_if.K)), 0);
    RESETn = 1'b1;
    @(negedge clk);

    foreach (directed[i]) issue(directed[i], (i % 2 == 0) ? 3 : 0);
    for (int i = 0; i < 150; i++) issue(16'($urandom) >> $urandom_range(0, 16), $urandom_range(0, 3));
    drain();

    // Reset in the middle of a long normalization must drop the result silently.
    bus_if.START = 1'b1;
    bus_if.IN    = 16'h0001;
    @(negedge clk);
    bus_if.START = 1'b0;
    repeat (3) @(negedge clk);
    RESETn = 1'b0;
    #1;
    check("midrst_ready", int'(bus_if.READY), 1);
    check("midrst_valid", int'(bus_if.VALID), 0);
    check("midrst_out", int'(bus_if.OUT), 0);
    check("midrst_k", int'($signed(bus_if.K)), 0);
    check("midrst_flag", int'(bus_if.FLAG), 0);
    repeat (2) @(negedge clk);
    RESETn = 1'b1;
    repeat (12) @(negedge clk);

    issue(16'h0E80, 2);
    for (int i = 0; i < 40; i++) issue(16'($urandom) >> $urandom_range(0, 16), $urandom_range(0, 2));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
